// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue FSM in front of the combinational 8-bit ALU; registers the ALU result.
// Optional macro ALU_CMDSEQ_ZERO_FLAG_EN adds a registered res_zero output.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CTRL_W-1:0] cmd_ctrl,
  input  logic [DATA_W-1:0] cmd_x,
  input  logic [DATA_W-1:0] cmd_y,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
`ifdef ALU_CMDSEQ_ZERO_FLAG_EN
  output logic              res_zero,
`endif
  output logic              busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t            state_q, state_d;
  cmd_t              mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  cmd_t              issue_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_carry_q;
  logic              push, pop, capture, release_res;

  // Ready depends only on the registered count, so a full FIFO never sees push+pop.
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (res_ready) begin
        release_res = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      issue_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        issue_q  <= mem_q[rd_ptr_q];
      end
      if (capture) begin
        res_valid_q <= 1'b1;
        res_data_q  <= alu_out;
        res_carry_q <= alu_carry;
      end else if (release_res) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{ctrl: cmd_ctrl, x: cmd_x, y: cmd_y};
  end

`ifdef ALU_CMDSEQ_ZERO_FLAG_EN
  logic res_zero_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          res_zero_q <= 1'b0;
    else if (capture) res_zero_q <= (alu_out == '0);
  end
  assign res_zero = res_zero_q;
`endif

  assign alu_ctrl  = issue_q.ctrl;
  assign alu_x     = issue_q.x;
  assign alu_y     = issue_q.y;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed + randomized bench for alu_cmd_sequencer with a behavioural ALU and an in-order result model.
module tb_alu_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_ctrl, alu_ctrl;
  logic [7:0] cmd_x, cmd_y, alu_x, alu_y, alu_out, res_data;
  logic       alu_carry, res_valid, res_ready, res_carry, busy;
`ifdef ALU_CMDSEQ_ZERO_FLAG_EN
  logic       res_zero;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] c;
    logic [7:0] x;
    logic [7:0] y;
  } cmd_s;
  cmd_s q[$];

  always #5 clk = ~clk;

  // Stand-in ALU: add/sub report carry/borrow in bit 8.
  function automatic logic [8:0] alu_f(logic [3:0] c, logic [7:0] x, logic [7:0] y);
    case (c)
      4'd0:    return {1'b0, x} + {1'b0, y};
      4'd1:    return {1'b0, x} - {1'b0, y};
      4'd2:    return {1'b0, x & y};
      4'd3:    return {1'b0, x | y};
      default: return {1'b0, x ^ y};
    endcase
  endfunction

  logic [8:0] alu_r;
  assign alu_r     = alu_f(alu_ctrl, alu_x, alu_y);
  assign alu_out   = alu_r[7:0];
  assign alu_carry = alu_r[8];

  alu_cmd_sequencer #(.DEPTH(4), .DATA_W(8), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ctrl(cmd_ctrl), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry),
`ifdef ALU_CMDSEQ_ZERO_FLAG_EN
    .res_zero(res_zero),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one command for one edge; the model records it only if the DUT can accept it.
  task automatic send(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    cmd_valid = 1'b1; cmd_ctrl = c; cmd_x = x; cmd_y = y;
    if (cmd_ready) q.push_back('{c: c, x: x, y: y});
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called when res_valid is visible and res_ready is high: the result is consumed at the next edge.
  task automatic expect_result(input string tag);
    logic [8:0] e;
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    if (q.size() == 0) begin
      chk({tag, "_unexpected"}, 32'(q.size()), 32'd1);
    end else begin
      e = alu_f(q[0].c, q[0].x, q[0].y);
      chk({tag, "_data"}, 32'(res_data), 32'(e[7:0]));
      chk({tag, "_carry"}, 32'(res_carry), 32'(e[8]));
`ifdef ALU_CMDSEQ_ZERO_FLAG_EN
      chk({tag, "_zero"}, 32'(res_zero), 32'(e[7:0] == 8'd0));
`endif
      void'(q.pop_front());
    end
  endtask

  task automatic drain(input string tag, input int budget);
    res_ready = 1'b1;
    for (int n = 0; n < budget && q.size() > 0; n++) begin
      if (res_valid) expect_result(tag);
      tick();
    end
    chk({tag, "_left"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hx, hd, nx;
    logic       hc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_ctrl = '0; cmd_x = '0; cmd_y = '0; res_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu", {alu_ctrl, alu_x, alu_y}, 32'd0);
    chk("rst_res", {res_carry, res_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Single command, latency
    res_ready = 1'b1;
    send(4'd0, 8'd5, 8'd4);
    chk("lat_n0_alu_x", 32'(alu_x), 32'd0);
    tick();
    chk("lat_n1_alu_x", 32'(alu_x), 32'd5);
    chk("lat_n1_alu_y", 32'(alu_y), 32'd4);
    chk("lat_n1_valid", 32'(res_valid), 32'd0);
    tick();
    chk("lat_n2_data", 32'(res_data), 32'd9);
    chk("lat_n2_carry", 32'(res_carry), 32'd0);
    expect_result("single");
    tick();
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_valid", 32'(res_valid), 32'd0);

    // Carry capture
    send(4'd0, 8'd200, 8'd100);
    tick(); tick();
    chk("carry_data", 32'(res_data), 32'd44);
    chk("carry_carry", 32'(res_carry), 32'd1);
    expect_result("carry");
    tick();

    // Fill to full with the consumer stalled
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'(i), 8'($urandom), 8'($urandom));
    chk("fill_accepted", 32'(q.size()), 32'd5);
    chk("fill_full_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_ctrl = 4'd7; cmd_x = 8'hAA; cmd_y = 8'h55;
      tick();
      chk("full_ready_low", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;

    // Backpressure in HOLD
    hx = alu_x; hd = res_data; hc = res_carry;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_frozen", {res_carry, res_data, alu_x}, {15'd0, hc, hd, hx});
    end
    res_ready = 1'b1;
    expect_result("fill");
    nx = q[0].x;
    tick();
    chk("bp_issue_x", 32'(alu_x), 32'(nx));
    chk("bp_issue_valid", 32'(res_valid), 32'd0);
    drain("fill", 40);
    tick(); tick();
    chk("fill_no_extra_valid", 32'(res_valid), 32'd0);
    chk("fill_no_extra_busy", 32'(busy), 32'd0);

    // Reset while executing with two queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd0, 8'(i + 1), 8'd3);
    res_ready = 1'b1;
    expect_result("pre_rst");
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_alu_x", 32'(alu_x), 32'd0);
    q.delete();
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_valid", 32'(res_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

`ifdef ALU_CMDSEQ_ZERO_FLAG_EN
    send(4'd0, 8'd0, 8'd0);
    tick(); tick();
    chk("zero_set", 32'(res_zero), 32'd1);
    expect_result("zero_a");
    tick();
    send(4'd0, 8'd1, 8'd0);
    tick(); tick();
    chk("zero_clr", 32'(res_zero), 32'd0);
    expect_result("zero_b");
    tick();
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      chk("rand_busy", 32'(busy), 32'(q.size() != 0));
      res_ready = ($urandom_range(0, 3) != 0);
      cmd_valid = $urandom_range(0, 1);
      cmd_ctrl  = 4'($urandom_range(0, 5));
      cmd_x     = 8'($urandom);
      cmd_y     = 8'($urandom);
      if (res_valid && res_ready) expect_result("rand");
      if (cmd_valid && cmd_ready) q.push_back('{c: cmd_ctrl, x: cmd_x, y: cmd_y});
      tick();
    end
    cmd_valid = 1'b0;
    drain("rand_drain", 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
